johnson_rx_checker: RTL
=======================

JOHNSON_RX_CHECKER -- requirements
Module: johnson_rx_checker

Interface
REQ-001 Parameter WIDTH, default 8: Johnson code width; 2*WIDTH states; WIDTH >= 2.
REQ-002 Parameter LOCK_N, default 4: consecutive in-sequence samples required for lock.
REQ-003 Local IDXW = clog2(2*WIDTH): index width.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sample_valid  input  1  code_in is sampled this cycle.
REQ-007 code_in  input  WIDTH  Johnson code from the counter under test.
REQ-008 index  output  IDXW  decoded state index of the last legal sample.
REQ-009 index_valid  output  1  one-cycle pulse: index updated.
REQ-010 locked  output  1  checker synchronised to the sequence.
REQ-011 err_pulse  output  1  one-cycle pulse on any counted error.
REQ-012 reg_req, reg_we, reg_addr[1:0], reg_wdata[31:0]  input  register access strobe, write enable, address, write data.
REQ-013 reg_ack  output  1, reg_rdata  output  32  access acknowledge and read data.

Function
REQ-014 Legal code SHALL be 0, or k contiguous ones from bit 0 (k=1..WIDTH), or k contiguous ones ending at bit WIDTH-1 (k=1..WIDTH-1); all else illegal.
REQ-015 Decoded index SHALL be popcount if code[0]=1 or code=0, else 2*WIDTH-popcount (WIDTH=4: 0011->2, 1110->5, 1000->7).
REQ-016 Sampling on sample_valid at edge N SHALL produce index, index_valid, err_pulse, locked updates at edge N+1 (latency 1); no update without sample_valid.
REQ-017 Illegal sample: index unchanged, index_valid low, illegal error counted in every state.
REQ-018 Legal sample: index updated, index_valid high; classified against previous index as ADVANCE (prev+1 mod 2*WIDTH, wrap 2*WIDTH-1->0 included), REPEAT (equal), or JUMP (other).
REQ-019 FSM states SEARCH, LOCKED; reset state SEARCH, locked=1 only in LOCKED.
REQ-020 SEARCH: ADVANCE increments run counter; run reaching LOCK_N -> LOCKED; JUMP or illegal resets run to 0; REPEAT holds run; first legal sample after reset/loss only seeds the previous index (run stays 0).
REQ-021 LOCKED: ADVANCE and REPEAT stay; JUMP counts a sequence error and -> SEARCH with run 0; illegal counts an illegal error and -> SEARCH.
REQ-022 JUMP in SEARCH SHALL NOT be counted as an error.
REQ-023 err_pulse SHALL assert for exactly the cycles in which either error counter would increment.
REQ-024 ILL_CNT and SEQ_CNT are 16-bit counters saturating at 0xFFFF.
REQ-025 Register map: 0 STATUS {locked[8], run[7:IDXW+... packed as run in bits 15:8], index in bits IDXW-1:0 -- fixed layout: bit31 locked, bits15:8 run, bits7:0 index zero-extended}; 1 ILL_CNT; 2 SEQ_CNT; 3 CTRL (write bit0=1 clears both counters, bit1=1 forces SEARCH; reads 0).
REQ-026 reg_ack SHALL pulse one cycle after reg_req, reg_rdata valid with it, zero otherwise; writes to 0-2 ignored; back-to-back requests each acked.
REQ-027 Clear write coincident with an error SHALL win: counter reads 0 afterwards.
REQ-028 Force-SEARCH coincident with a sample SHALL win: state SEARCH, run 0, sample seeds previous index.

Reset
REQ-029 On reset: state SEARCH, run 0, index 0, previous-index-seeded flag 0, counters 0, all outputs 0.
REQ-030 Reset asserted mid-stream or mid-access SHALL override all other activity in that cycle; a pending reg_ack is dropped.

Structure
REQ-031 Package johnson_rx_pkg SHALL hold FSM state encoding, register addresses, CTRL bit positions, and counter width 16.
REQ-032 Combinational sub-module johnson_decode (code_in -> legal, index) SHALL be instantiated once; all sequential logic stays in johnson_rx_checker.

Verification (WIDTH=4, LOCK_N=4)
REQ-033 Codes 0000,0001,0011,0111,1111 on consecutive valid cycles -> locked rises one cycle after fifth sample, index=4, ILL_CNT=SEQ_CNT=0.
REQ-034 Locked, index 7 (1000) then 0000 -> wrap accepted, index 0, locked stays 1, no err_pulse.
REQ-035 Locked, 0011 then 1100 -> SEQ_CNT=1, err_pulse one cycle, locked falls, index=6.
REQ-036 0101 applied in SEARCH and LOCKED -> ILL_CNT increments each time, index unchanged, index_valid low.
REQ-037 ILL_CNT preset to 0xFFFF via 65535 illegal samples, one more -> stays 0xFFFF; CTRL write 0x1 on same cycle as an illegal sample -> reads 0.
REQ-038 Reset asserted while locked with reg_req pending -> next cycle locked=0, reg_ack=0, all counters read 0.

Source files
------------

// File: rtl/johnson_rx_pkg.sv
// Shared definitions for the Johnson-code receive checker: FSM encoding,
// register map, CTRL bit positions and counter sizing.
package johnson_rx_pkg;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [1:0] ADDR_STATUS  = 2'd0;
   localparam logic [1:0] ADDR_ILL_CNT = 2'd1;
   localparam logic [1:0] ADDR_SEQ_CNT = 2'd2;
   localparam logic [1:0] ADDR_CTRL    = 2'd3;

   localparam int CTRL_CLEAR_BIT  = 0;
   localparam int CTRL_SEARCH_BIT = 1;

   localparam int CNT_W = 16;
   localparam int RUN_W = 8;

   // Error counters stick at all-ones rather than wrapping back to zero
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == '1) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson-code decoder: flags legal codes and converts them to
// their position in the 2*WIDTH state sequence.
module johnson_decode
   import johnson_rx_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int IDXW  = $clog2(2*WIDTH)
) (
   input  logic [WIDTH-1:0] code,
   output logic             legal,
   output logic [IDXW-1:0]  index
);

   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [IDXW:0]    TWO_W = (IDXW+1)'(2*WIDTH);

   logic [WIDTH-1:0] inv;
   logic [IDXW:0]    ones;

   // A run of ones anchored at bit 0 is x with x&(x+1)==0; a run anchored at
   // the MSB is the same test applied to the inverted code.
   always_comb begin
      inv   = ~code;
      ones  = '0;
      legal = 1'b0;
      index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + (IDXW+1)'(code[i]);
      end
      if (code == '0) begin
         legal = 1'b1;
      end else if (code[0]) begin
         legal = ((code & (code + ONE)) == '0);
         index = ones[IDXW-1:0];
      end else begin
         legal = ((inv & (inv + ONE)) == '0);
         index = IDXW'(TWO_W - ones);
      end
   end

endmodule

// File: rtl/johnson_rx_checker.sv
// Watches a Johnson counter's output, locks onto an advancing sequence and
// counts illegal codes and sequence breaks; status and counters via registers.
module johnson_rx_checker
   import johnson_rx_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int LOCK_N = 4,
   localparam int IDXW   = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] code_in,
   output logic [IDXW-1:0]  index,
   output logic             index_valid,
   output logic             locked,
   output logic             err_pulse,
   input  logic             reg_req,
   input  logic             reg_we,
   input  logic [1:0]       reg_addr,
   input  logic [31:0]      reg_wdata,
   output logic             reg_ack,
   output logic [31:0]      reg_rdata
);

   localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(2*WIDTH-1);
   localparam logic [IDXW-1:0]  ONE_IDX  = IDXW'(1);
   localparam logic [RUN_W-1:0] ONE_RUN  = RUN_W'(1);
   localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_N);

   state_t           state, state_next;
   logic [RUN_W-1:0] run, run_next, run_inc;
   logic             seeded, seeded_next;
   logic [CNT_W-1:0] ill_cnt, seq_cnt;
   logic             dec_legal;
   logic [IDXW-1:0]  dec_index;
   logic [IDXW-1:0]  adv_index;
   logic             is_advance, is_repeat;
   logic             ctrl_write, force_search, clear_cnt;
   logic             ill_hit, seq_hit;
   logic [31:0]      read_data;
   logic             unused_wdata;

   johnson_decode #(.WIDTH(WIDTH)) u_decode (
      .code  (code_in),
      .legal (dec_legal),
      .index (dec_index)
   );

   assign locked       = (state == LOCKED);
   assign adv_index    = (index == LAST_IDX) ? '0 : index + ONE_IDX;
   assign is_advance   = (dec_index == adv_index);
   assign is_repeat    = (dec_index == index);
   assign run_inc      = run + ONE_RUN;
   assign ctrl_write   = reg_req && reg_we && (reg_addr == ADDR_CTRL);
   assign force_search = ctrl_write && reg_wdata[CTRL_SEARCH_BIT];
   assign clear_cnt    = ctrl_write && reg_wdata[CTRL_CLEAR_BIT];
   assign unused_wdata = ^reg_wdata[31:2];

   // Lock tracking. The index register doubles as the previous index, and
   // 'seeded' says whether it holds a real sample worth classifying against.
   always_comb begin
      state_next  = state;
      run_next    = run;
      seeded_next = seeded;
      ill_hit     = sample_valid && !dec_legal;
      seq_hit     = 1'b0;
      if (force_search) begin
         state_next  = SEARCH;
         run_next    = '0;
         seeded_next = sample_valid && dec_legal;
      end else if (sample_valid) begin
         if (!dec_legal) begin
            run_next = '0;
            if (state == LOCKED) begin
               state_next  = SEARCH;
               seeded_next = 1'b0;
            end
         end else if (!seeded) begin
            seeded_next = 1'b1;
            run_next    = '0;
         end else begin
            case (state)
               SEARCH: begin
                  if (is_advance) begin
                     run_next = run_inc;
                     if (run_inc >= LOCK_RUN) state_next = LOCKED;
                  end else if (!is_repeat) begin
                     run_next = '0;
                  end
               end
               LOCKED: begin
                  if (!is_advance && !is_repeat) begin
                     seq_hit    = 1'b1;
                     state_next = SEARCH;
                     run_next   = '0;
                  end
               end
               default: state_next = SEARCH;
            endcase
         end
      end
   end

   always_comb begin
      read_data = '0;
      case (reg_addr)
         ADDR_STATUS:  read_data = {locked, 15'b0, run, 8'(index)};
         ADDR_ILL_CNT: read_data = {16'b0, ill_cnt};
         ADDR_SEQ_CNT: read_data = {16'b0, seq_cnt};
         default:      read_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= SEARCH;
         run    <= '0;
         seeded <= 1'b0;
      end else begin
         state  <= state_next;
         run    <= run_next;
         seeded <= seeded_next;
      end
   end

   // Outputs, counters and the register port; a clear beats a same-cycle error
   always_ff @(posedge clk) begin
      if (reset) begin
         index       <= '0;
         index_valid <= 1'b0;
         err_pulse   <= 1'b0;
         ill_cnt     <= '0;
         seq_cnt     <= '0;
         reg_ack     <= 1'b0;
         reg_rdata   <= '0;
      end else begin
         if (sample_valid && dec_legal) index <= dec_index;
         index_valid <= sample_valid && dec_legal;
         err_pulse   <= ill_hit || seq_hit;
         if (clear_cnt) begin
            ill_cnt <= '0;
            seq_cnt <= '0;
         end else begin
            if (ill_hit) ill_cnt <= sat_inc(ill_cnt);
            if (seq_hit) seq_cnt <= sat_inc(seq_cnt);
         end
         reg_ack   <= reg_req;
         reg_rdata <= (reg_req && !reg_we) ? read_data : '0;
      end
   end

endmodule
